spi_flash_reader: RTL



---
 rtl/spi_flash_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: Wishbone read-only slave fetching 32-bit words from SPI flash with READ (0x03).
// Each bus read runs one chip-select-framed mode-0 transaction: cmd, 24-bit address, 4 data bytes.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        sck_o,
    output logic        ss_o,
    output logic        mosi_o,
    input  logic        miso_i
);
    localparam int unsigned GAP_N  = (CLK_DIV < 2) ? 2 : CLK_DIV;
    localparam logic [7:0]  DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [7:0]  GAP_M1 = 8'(GAP_N - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, ACK, GAP} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  bit_q, bit_d;
    logic [63:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d, dat_q, dat_d;
    logic        sck_q, sck_d, ss_q, ss_d, mosi_q, mosi_d, ack_q, ack_d, err_q, err_d;
    logic        req, cnt_done;
    logic        unused;

    assign req      = wb_cyc_i & wb_stb_i;
    assign cnt_done = cnt_q == DIV_M1;
    assign unused   = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:24], wb_adr_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dat_q   <= '0;
            sck_q   <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dat_q   <= dat_d;
            sck_q   <= sck_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_done ? '0 : cnt_q + 8'd1;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dat_d   = dat_q;
        sck_d   = sck_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // err_q guard keeps a held write strobe from producing a second error pulse
                if (req && !err_q) begin
                    if (wb_we_i) begin
                        err_d = 1'b1;
                    end else begin
                        tx_d    = {READ_CMD, wb_adr_i[23:2], 2'b00, 32'h0};
                        ss_d    = 1'b0;
                        mosi_d  = tx_d[63];
                        state_d = SETUP;
                    end
                end
            end
            SETUP: state_d = cnt_done ? SHIFT : SETUP;
            SHIFT: begin
                if (cnt_done) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[30:0], miso_i};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 7'd63) begin
                            bit_d   = '0;
                            mosi_d  = 1'b0;
                            state_d = HOLD;
                        end else begin
                            bit_d  = bit_q + 7'd1;
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[62];
                        end
                    end
                end
            end
            HOLD: state_d = cnt_done ? ACK : HOLD;
            ACK: begin
                // deselect and acknowledge land together; an aborted cycle just skips the ack
                ss_d    = 1'b1;
                dat_d   = rx_q;
                ack_d   = req;
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                cnt_d   = (cnt_q == GAP_M1) ? '0 : cnt_q + 8'd1;
                state_d = (cnt_q == GAP_M1) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign sck_o    = sck_q;
    assign ss_o     = ss_q;
    assign mosi_o   = mosi_q;
endmodule
